// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a valid/ready input, a circular
// transmit FIFO, configurable data width, optional parity and 1 or 2 stop
// bits. Queued words go out back-to-back with no idle bit between frames.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        asynchronous active-low reset (flushes FIFO, aborts frame)
//   data       word to transmit (DATA_BITS wide)
//   valid      producer has a word on data
//   ready      FIFO can accept; word taken on an edge with valid && ready
//   tx         serial line, idle high, LSB first
//   busy       a frame is in progress
//   fifo_count words queued, not counting the frame on the line
module uart_tx_fifo #(
    parameter int F          = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_BITS-1:0]        data,
    input  logic                        valid,
    output logic                        ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int DIV  = (F + BAUD / 2) / BAUD;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int BCW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BCW-1:0]  BAUD_LAST = BCW'(DIV - 1);
    localparam logic [BCW-1:0]  BAUD_ZERO = BCW'(0);
    localparam logic [BCW-1:0]  BAUD_ONE  = BCW'(1);
    localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(FIFO_DEPTH);
    localparam logic [CNTW-1:0] CNT_EMPTY = CNTW'(0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] word);
        return (^word) ^ ((PARITY == 1) ? 1'b1 : 1'b0);
    endfunction

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

    state_t               state_q, state_d;
    logic [BCW-1:0]       baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]      count_q, count_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;
    logic                 push_s, pop_s, baud_end_s;
    logic [DATA_BITS-1:0] head_s;

    // Next-state logic: frame sequencer, FIFO bookkeeping and registered outputs.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        pop_s      = 1'b0;
        push_s     = valid && ready_q;
        head_s     = mem[rd_ptr_q];
        baud_end_s = (baud_q == BAUD_LAST);

        case (state_q)
            S_IDLE: begin
                if (count_q != CNT_EMPTY) begin
                    pop_s   = 1'b1;
                    shift_d = head_s;
                    par_d   = parity_of(head_s);
                    baud_d  = BAUD_ZERO;
                    bit_d   = 4'd0;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (baud_end_s) begin
                    baud_d  = BAUD_ZERO;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_DATA: begin
                if (baud_end_s) begin
                    baud_d = BAUD_ZERO;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = 4'd0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_PAR: begin
                if (baud_end_s) begin
                    baud_d  = BAUD_ZERO;
                    bit_d   = 4'd0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_STOP: begin
                if (baud_end_s) begin
                    baud_d = BAUD_ZERO;
                    if (bit_q == STOP_LAST) begin
                        bit_d = 4'd0;
                        // Chain straight into the next start bit when more is queued.
                        if (count_q != CNT_EMPTY) begin
                            pop_s   = 1'b1;
                            shift_d = head_s;
                            par_d   = parity_of(head_s);
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = BAUD_ZERO;
                bit_d   = 4'd0;
            end
        endcase

        // Pointers wrap naturally because the depth is a power of two.
        wr_ptr_d = wr_ptr_q + AW'(push_s);
        rd_ptr_d = rd_ptr_q + AW'(pop_s);
        count_d  = count_q + CNTW'(push_s) - CNTW'(pop_s);

        // Line level is derived from the next state so tx moves on the same
        // edge as the state change.
        case (state_d)
            S_IDLE:  tx_d = 1'b1;
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            S_PAR:   tx_d = par_d;
            S_STOP:  tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        busy_d  = (state_d != S_IDLE);
        ready_d = (count_d != CNT_FULL);
    end

    // State, counters, pointers and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            baud_q   <= BAUD_ZERO;
            bit_q    <= 4'd0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= CNT_EMPTY;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem[wr_ptr_q] <= data;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign ready      = ready_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: four uart_tx_fifo instances in different configurations
// driven in parallel. Each accepted word is turned into an expected frame
// (start time plus bit list) by a transaction-level model; a per-instance
// monitor decodes the serial line and compares against that queue.
module tb_uart_tx_fifo;

    typedef struct {
        int w;
        int push;
        int pop;
    } ent_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    // Edge counter: after rising edge number N, cyc == N.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int inst, input bit ok, input string nm, input int act, input int exp_v);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL u%0d %s at cycle %0d: actual=%0d expected=%0d", inst, nm, cyc, act, exp_v);
        end
    endtask

    // Level of bit b of the frame carrying word w (b=0 is the start bit).
    function automatic int exp_bit(int w, int b, int db, int par);
        int ones;
        if (b == 0) return 0;
        if (b <= db) return (w >> (b - 1)) & 1;
        if (par != 0 && b == db + 1) begin
            ones = $countones(w & ((1 << db) - 1));
            return (par == 2) ? (ones % 2) : (1 - (ones % 2));
        end
        return 1;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : gi
        localparam int FQ   = (g == 0) ? 50000000 : (g == 1) ? 1000 : (g == 2) ? 700 : 500;
        localparam int BR   = (g == 0) ? 115200 : 100;
        localparam int DB   = (g == 2) ? 7 : (g == 3) ? 9 : 8;
        localparam int PAR  = (g == 1) ? 2 : (g == 3) ? 1 : 0;
        localparam int SB   = (g == 2) ? 2 : 1;
        localparam int FD   = (g == 1) ? 4 : (g == 3) ? 2 : 8;
        localparam int DIV  = (FQ + BR / 2) / BR;
        localparam int NB   = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
        localparam int L    = NB * DIV;

        logic                     rst = 1'b1;
        logic [DB-1:0]            data = '0;
        logic                     valid = 1'b0;
        logic                     ready, tx, busy;
        logic [$clog2(FD):0]      fifo_count;

        ent_t pend[$];
        ent_t expq[$];
        int   last_end = 0;
        int   last_pop = 0;
        int   nacc = 0;
        int   head = 0;
        int   mc, k, bad, cur_w, eb, act_b, exp_b, base, e2;
        bit   in_frame = 1'b0;
        bit   rogue = 1'b0;

        uart_tx_fifo #(
            .F(FQ), .BAUD(BR), .DATA_BITS(DB), .PARITY(PAR),
            .STOP_BITS(SB), .FIFO_DEPTH(FD)
        ) dut (
            .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(ready),
            .tx(tx), .busy(busy), .fifo_count(fifo_count)
        );

        // Words held by the FIFO after edge n.
        function automatic int model_count(int n);
            int c = 0;
            foreach (pend[i]) if (pend[i].push <= n && pend[i].pop > n) c++;
            return c;
        endfunction

        // A word pushed at edge pe starts one edge later, or when the line frees up.
        task automatic record(input int w, input int pe);
            ent_t e;
            e.w    = w;
            e.push = pe;
            e.pop  = (pe + 1 > last_end) ? pe + 1 : last_end;
            last_end = e.pop + L;
            last_pop = e.pop;
            pend.push_back(e);
            expq.push_back(e);
        endtask

        task automatic drive(input bit v, input int w);
            data  = w[DB-1:0];
            valid = v;
            if (v && rst && model_count(cyc) != FD) record(w & ((1 << DB) - 1), cyc + 1);
            @(negedge clk);
        endtask

        task automatic wait_idle(input int budget);
            int n = 0;
            while ((cyc < last_end || in_frame) && n < budget) begin
                @(negedge clk);
                n++;
            end
            chk(g, cyc >= last_end && !in_frame, "drain_timeout", cyc, last_end);
        endtask

        always @(posedge clk) if (rst && valid && ready) nacc <= nacc + 1;

        // Monitor: FIFO occupancy, handshake, and serial frame decode.
        always @(negedge clk) begin
            mc = model_count(cyc);
            chk(g, int'(fifo_count) == mc, "fifo_count", int'(fifo_count), mc);
            chk(g, ready === (mc != FD), "ready", int'(ready), int'(mc != FD));
            if (!rst) begin
                in_frame = 1'b0;
                head     = expq.size();
                chk(g, tx === 1'b1 && busy === 1'b0, "reset_tx_busy", int'({tx, busy}), 2);
            end else begin
                if (!in_frame && head < expq.size() && expq[head].pop < cyc) begin
                    chk(g, expq[head].pop >= cyc, "frame_missed", cyc, expq[head].pop);
                    head++;
                end
                if (!in_frame) begin
                    if (head < expq.size() && expq[head].pop == cyc) begin
                        chk(g, tx === 1'b0, "start_edge", int'(tx), 0);
                        cur_w    = expq[head].w;
                        head++;
                        in_frame = 1'b1;
                        rogue    = 1'b0;
                        k        = 0;
                        bad      = 0;
                    end else begin
                        chk(g, tx === 1'b1 && busy === 1'b0, "idle_line", int'({tx, busy}), 2);
                        if (tx === 1'b0) begin
                            in_frame = 1'b1;
                            rogue    = 1'b1;
                            k        = 0;
                        end
                    end
                end
                if (in_frame) begin
                    if (!rogue) begin
                        eb = exp_bit(cur_w, k / DIV, DB, PAR);
                        if (tx !== eb[0] || busy !== 1'b1) begin
                            bad++;
                            act_b = int'(tx) + 2 * int'(busy);
                            exp_b = eb + 2;
                        end
                        if (k % DIV == DIV - 1) begin
                            chk(g, bad == 0, "frame_bit", act_b, exp_b);
                            bad = 0;
                        end
                    end
                    k++;
                    if (k == L) in_frame = 1'b0;
                end
            end
        end

        initial begin
            #1 rst = 1'b0;
            valid = 1'b1;
            @(negedge clk);
            if (g == 0) begin
                base = nacc;
                repeat (10) drive(1'b1, 'hAA);
                chk(g, nacc == base, "reset_no_accept", nacc - base, 0);
                rst = 1'b1;
                drive(1'b0, 0);
                // Single 8N1 frame of 0xD3.
                drive(1'b1, 'hD3);
                drive(1'b0, 0);
                wait_idle(L + 50);
                chk(g, busy === 1'b0, "busy_after_frame", int'(busy), 0);
                // Overflow: 12 consecutive offers, 9 taken.
                base = nacc;
                for (int i = 0; i < 12; i++) drive(1'b1, 'h10 + i * 13);
                drive(1'b0, 0);
                chk(g, nacc - base == 9, "overflow_accepted", nacc - base, 9);
                wait_idle(9 * L + 100);
                // Reset in the middle of a frame with words still queued.
                drive(1'b1, 'h5A);
                drive(1'b1, 'h3C);
                drive(1'b1, 'h99);
                repeat (1500) drive(1'b0, 0);
                #2 rst = 1'b0;
                pend.delete();
                last_end = 0;
                #1;
                chk(g, tx === 1'b1, "midreset_tx", int'(tx), 1);
                chk(g, busy === 1'b0, "midreset_busy", int'(busy), 0);
                chk(g, fifo_count == '0, "midreset_count", int'(fifo_count), 0);
                @(negedge clk);
                repeat (3) drive(1'b0, 0);
                rst = 1'b1;
                repeat (5000) drive(1'b0, 0);
            end else begin
                repeat (3) drive(1'b0, 0);
                rst = 1'b1;
                drive(1'b0, 0);
                drive(1'b1, (g == 2) ? 'h2C : 'hD3);
                drive(1'b0, 0);
                wait_idle(L + 20);
                if (g == 1) begin
                    // Push lands on the very edge the second word is popped.
                    drive(1'b1, 1);
                    drive(1'b1, 2);
                    e2 = last_pop;
                    drive(1'b1, 3);
                    drive(1'b1, 4);
                    while (cyc < e2 - 1) drive(1'b0, 0);
                    drive(1'b1, 5);
                    chk(g, fifo_count == 3, "push_pop_same_edge", int'(fifo_count), 3);
                    drive(1'b0, 0);
                    wait_idle(6 * L);
                end
                for (int i = 0; i < 30; i++)
                    drive($urandom_range(0, 3) != 0, int'($urandom_range(0, (1 << DB) - 1)));
                drive(1'b0, 0);
                wait_idle(40 * L);
            end
            done_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 95000 && done_cnt < 4; i++) @(negedge clk);
        chk(9, done_cnt == 4, "all_done", done_cnt, 4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, next generation of the single-byte uart_tx. It adds a valid/ready input handshake, an internal transmit FIFO, configurable data width, optional parity and 1 or 2 stop bits. It sits between any byte producer (CPU bus, packetiser) and the board TX pin, driving a back-to-back serial stream with no idle gaps while data is queued.

Parameters:
F, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s; DIV = (F + BAUD/2) / BAUD clocks per bit (434 at defaults)
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 8, FIFO entries, power of two, at least 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
data  input  DATA_BITS  word to transmit
valid  input  1  producer has a word on data
ready  output  1  FIFO can accept; word taken on the edge where valid && ready
tx  output  1  serial line, idle high
busy  output  1  frame in progress (state != IDLE)
fifo_count  output  $clog2(FIFO_DEPTH)+1  words queued, not counting the frame on the line

Behaviour:
- Reset (rst low, asynchronous): tx=1, ready=1, busy=0, fifo_count=0, FIFO pointers 0, state IDLE, baud and bit counters 0. Applies immediately, including mid-frame. The partial frame is abandoned and queued words are flushed.
- ready = (fifo_count != FIFO_DEPTH). A push occurs when valid && ready. data is stored unmodified.
- FIFO: circular buffer with wrap-around read/write pointers. A push and a pop on the same edge leave fifo_count unchanged. A pop never occurs when empty. No push is possible when full because ready=0.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: tx=1. If fifo_count>0, pop the head word into the shift register, clear the baud counter and go to START.
  - START: tx=0 for DIV clocks, then go to DATA.
  - DATA: tx = shift[0], LSB first. Shift right each DIV clocks. After DATA_BITS bits, go to PAR if PARITY!=0, else go to STOP.
  - PAR: tx = parity bit for DIV clocks. Even: XOR of data bits. Odd: inverted XOR.
  - STOP: tx=1 for STOP_BITS*DIV clocks. At the end, if fifo_count>0, pop and go directly to START with no idle cycle; otherwise go to IDLE.
- Baud counter: counts 0..DIV-1 and wraps. Each bit lasts exactly DIV clocks.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIV clocks.
- Latency: a word pushed at edge N into an empty FIFO with state IDLE is popped at edge N+1. tx falls after edge N+1.
- busy=1 from the pop edge until return to IDLE.
- Timing is independent of producer activity. A push during a frame never disturbs the frame.

Test Plan:
- Reset: hold rst=0 for 10 clocks with valid=1 -> tx=1, ready=1, busy=0, fifo_count=0, no word accepted. Repeat with rst asserted mid-frame -> tx=1 in the same cycle, fifo_count=0, and no further frame after release.
- Defaults (8N1, DIV=434), single push of 0xD3 -> tx sequence 0,1,1,0,0,1,0,1,1,1, each level exactly 434 clocks. Total 4340 clocks, then busy=0.
- PARITY=2 and PARITY=1, push 0xD3 (five ones) -> parity bit 1 (even) and 0 (odd) after bit 7. Frame is 11*434 clocks.
- Overflow, defaults: valid=1 for 12 consecutive clocks with distinct words -> first 9 accepted (one popped immediately, 8 queued). ready=0 from the 10th clock until the first frame's stop bit ends. The 9 frames are emitted in order, back-to-back, 9*4340 clocks with no idle gap.
- DATA_BITS=7, STOP_BITS=2, push 0x2C -> tx sequence 0,0,0,1,1,0,1,0,1,1. Frame is 10*434 clocks.
- Push on the same edge as a pop with fifo_count=3 -> fifo_count stays 3. Write pointer wraps past FIFO_DEPTH-1 with data order preserved over 20 words.
